signed_seq_div: RTL and testbench
=================================

# signed_seq_div

Multi-cycle signed integer divider, the inverse companion of the combinational Booth multiplier in the FIR datapath. It takes an `OPERAND_SIZE`-bit two's-complement dividend and divisor and returns the quotient and remainder. It uses an unsigned radix-2 restoring core with sign pre- and post-processing. It sits behind a valid/ready handshake so that gain normalisation and coefficient scaling can share one instance.

## Interface
- `OPERAND_SIZE`, default `` `OPERAND_SIZE `` (8), operand, quotient and remainder width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  divider idle and able to accept.
- `dividend`  in  OPERAND_SIZE  signed dividend.
- `divisor`  in  OPERAND_SIZE  signed divisor.
- `out_valid`  out  1  result valid; held until accepted.
- `out_ready`  in  1  consumer accepts result.
- `quotient`  out  OPERAND_SIZE  signed quotient.
- `remainder`  out  OPERAND_SIZE  signed remainder.
- `div_by_zero`  out  1  divisor was 0.
- `overflow`  out  1  most-negative ÷ −1.

## Operation
- **FSM states:** IDLE, CALC, FIX, DONE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`:
    - Latch |dividend| and |divisor| as OPERAND_SIZE-bit unsigned values (|−2^(N−1)| = 2^(N−1) fits).
    - Latch sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
    - Latch the dz and ovf conditions.
    - Clear the partial remainder and the iteration counter, then go to CALC.
- **CALC:**
  - Runs exactly OPERAND_SIZE iterations, one per cycle, MSB first.
  - Each iteration: shift {R, Q} left by 1; if R ≥ |divisor|, then R −= |divisor| and Q[0] = 1.
  - R needs N+1 bits.
  - The counter reaching N−1 moves to FIX.
- **FIX:**
  - quotient = sign_q ? −Q : Q; remainder = sign_r ? −R : R.
  - Result is truncation toward zero; the remainder sign follows the dividend.
  - Division by zero: quotient = all-ones (−1), remainder = dividend, `div_by_zero`=1.
  - Overflow (−2^(N−1) ÷ −1): quotient = −2^(N−1) (wrapped), remainder = 0, `overflow`=1.
  - Register the outputs, set `out_valid`, and go to DONE.
- **DONE:**
  - Outputs stable while `out_valid`=1 and `out_ready`=0.
  - On `out_ready`: clear `out_valid` and go to IDLE.
- Flags are cleared at the next acceptance, not at output handshake.

## Timing
- **Reset:** async, while `rst_n`=0. State IDLE; `out_valid`, `quotient`, `remainder`, `div_by_zero` and `overflow` all 0.
- `in_ready` = (state==IDLE), combinational. It therefore reads 1 during and after reset; `in_valid` is ignored while `rst_n`=0.
- **Latency:** acceptance at edge k gives `out_valid`=1 after edge k+N+1 (N CALC edges, 1 FIX edge). This is fixed for all operands, including dz and ovf.
- **Throughput:** the earliest next acceptance is the edge after the output handshake (IDLE must be re-entered). The minimum period is N+3 cycles with `out_ready` tied high.
- `in_valid` outside IDLE is ignored, not queued; operands need not be held after acceptance.
- **Reset mid-CALC/FIX/DONE:** immediate abort, pending result discarded, `out_valid` drops asynchronously.
- All outputs other than `in_ready` are registered.

## Structure
- The shared header/package holds `OPERAND_SIZE` (already a codebase-wide define) and the FSM state encoding localparams (IDLE=0, CALC=1, FIX=2, DONE=3).
- Sub-module `signed_abs`: combinational two's-complement magnitude with sign output, instantiated twice (dividend, divisor). Post-negation is done inline.
- The counter is ceil(log2(N)) bits.

## Test plan
- **Basic quadrants:**
  - 100 ÷ 7 → q=14, r=2.
  - −100 ÷ 7 → q=−14, r=−2.
  - 100 ÷ −7 → q=−14, r=2.
  - −100 ÷ −7 → q=14, r=−2.
  - `out_valid` exactly N+1 edges after acceptance.
- **Extremes:**
  - −128 ÷ 127 → q=−1, r=−1.
  - −128 ÷ −110 → q=1, r=−18.
  - 127 ÷ −128 → q=0, r=127.
  - 3 ÷ 4 → q=0, r=3.
- **Overflow / div-by-zero:**
  - −128 ÷ −1 → q=−128, r=0, `overflow`=1.
  - 5 ÷ 0 → q=−1, r=5, `div_by_zero`=1.
  - Next 36 ÷ 4 → q=9, r=0, both flags 0.
- **Backpressure:**
  - Hold `out_ready`=0 for 5 cycles: outputs stable, `in_ready`=0.
  - `in_valid` pulses during CALC/DONE are ignored.
  - Release `out_ready`: IDLE the following cycle.
- **Back-to-back:** with `out_ready`=1, 16 random signed operand pairs. Every result matches a truncating reference model; acceptance spacing is N+3 cycles.
- **Reset mid-operation:**
  - Drop `rst_n` during CALC iteration 3: `out_valid` stays 0, `in_ready`=1 after release.
  - A fresh 72 ÷ −5 then yields q=−14, r=2.

Source files
------------

// File: rtl/signed_seq_div_pkg.sv
// Shared operand width, FSM state encoding and per-operation flag bundle for the signed divider.
// Constants and types only, so there is no latency and no flow control in this file.
`ifndef OPERAND_SIZE
`define OPERAND_SIZE 8
`endif

package signed_seq_div_pkg;

  localparam int DEFAULT_OPERAND_SIZE = `OPERAND_SIZE;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic sign_q;
    logic sign_r;
    logic dz;
    logic ovf;
  } op_flags_t;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/signed_abs.sv
// Two's-complement magnitude and sign; purely combinational with no handshake.
// The most negative input maps to 2^(W-1), which still fits as an unsigned W-bit value.
module signed_abs
  import signed_seq_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_OPERAND_SIZE
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] mag,
  output logic             sign
);

  assign sign = value[WIDTH-1];
  assign mag  = sign ? (~value + 1'b1) : value;

endmodule

// File: rtl/signed_seq_div.sv
// Signed restoring divider; out_valid rises N+1 edges after acceptance (N CALC, 1 FIX).
// Result is held until out_ready; in_ready is high only in IDLE and other in_valid pulses are dropped.
module signed_seq_div
  import signed_seq_div_pkg::*;
#(
  parameter int OPERAND_SIZE = DEFAULT_OPERAND_SIZE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OPERAND_SIZE-1:0] dividend,
  input  logic [OPERAND_SIZE-1:0] divisor,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OPERAND_SIZE-1:0] quotient,
  output logic [OPERAND_SIZE-1:0] remainder,
  output logic                    div_by_zero,
  output logic                    overflow
);

  localparam int N  = OPERAND_SIZE;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);
  localparam logic [N-1:0]  MOST_NEG  = {1'b1, {(N-1){1'b0}}};

  logic [1:0]    state;
  logic [N-1:0]  rem_q;
  logic [N-1:0]  quo_q;
  logic [N-1:0]  dvs_q;
  logic [CW-1:0] cnt_q;
  op_flags_t     flg_q;

  logic [N-1:0]  dvd_mag;
  logic [N-1:0]  dvs_mag;
  logic          dvd_sign;
  logic          dvs_sign;

  logic [N:0]    rem_sh;
  logic [N:0]    rem_sub;
  logic          fits;
  logic [N-1:0]  q_fix;
  logic [N-1:0]  r_fix;

  signed_abs #(.WIDTH(N)) u_abs_dividend (
    .value (dividend),
    .mag   (dvd_mag),
    .sign  (dvd_sign)
  );

  signed_abs #(.WIDTH(N)) u_abs_divisor (
    .value (divisor),
    .mag   (dvs_mag),
    .sign  (dvs_sign)
  );

  assign in_ready = (state == ST_IDLE);

  // Partial remainder stays below |divisor| <= 2^(N-1), so only the shifted value needs the extra bit;
  // the borrow out of the trial subtraction is the "R < |divisor|" decision.
  always_comb begin
    rem_sh  = {rem_q, quo_q[N-1]};
    rem_sub = rem_sh - {1'b0, dvs_q};
    fits    = ~rem_sub[N];
  end

  // With a zero divisor every trial subtraction succeeds, so R ends up as |dividend| and the
  // ordinary remainder sign fix-up already reproduces the dividend; only the quotient is forced.
  always_comb begin
    q_fix = flg_q.sign_q ? (~quo_q + 1'b1) : quo_q;
    r_fix = flg_q.sign_r ? (~rem_q + 1'b1) : rem_q;
    if (flg_q.dz) begin
      q_fix = '1;
    end else if (flg_q.ovf) begin
      q_fix = MOST_NEG;
      r_fix = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      flg_q       <= '0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            quo_q       <= dvd_mag;
            dvs_q       <= dvs_mag;
            rem_q       <= '0;
            cnt_q       <= '0;
            flg_q       <= op_flags_t'{
                             sign_q: dvd_sign ^ dvs_sign,
                             sign_r: dvd_sign,
                             dz:     (divisor == '0),
                             ovf:    (dividend == MOST_NEG) && (divisor == '1)
                           };
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            state       <= ST_CALC;
          end
        end
        ST_CALC: begin
          rem_q <= fits ? rem_sub[N-1:0] : rem_sh[N-1:0];
          quo_q <= {quo_q[N-2:0], fits};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          quotient    <= q_fix;
          remainder   <= r_fix;
          div_by_zero <= flg_q.dz;
          overflow    <= flg_q.ovf;
          out_valid   <= 1'b1;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_seq_div.sv
// Scoreboarded bench for signed_seq_div: directed corner operands, backpressure, back-to-back random
// operands and a mid-operation reset, checked against a plain-arithmetic truncating division model.
module tb_signed_seq_div;

  localparam int N   = 8;
  localparam int MIN = -(1 << (N - 1));

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    logic         ovf;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  exp_t sb[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  logic prev_vld = 1'b0;
  int   last_acc = -1;
  bit   check_spacing = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  signed_seq_div #(.OPERAND_SIZE(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int acc);
    exp_t m;
    int   q;
    int   r;
    m.dz  = 1'b0;
    m.ovf = 1'b0;
    if (b == 0) begin
      q    = -1;
      r    = a;
      m.dz = 1'b1;
    end else if (a == MIN && b == -1) begin
      q     = MIN;
      r     = 0;
      m.ovf = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
    end
    m.q   = q[N-1:0];
    m.r   = r[N-1:0];
    m.acc = acc;
    return m;
  endfunction

  // Monitor: samples just after the falling edge and pops on every output handshake.
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      prev_vld = 1'b0;
    end else begin
      if (out_valid && !prev_vld) rise_cyc = cyc;
      prev_vld = out_valid;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
          chk("div_by_zero", div_by_zero, e.dz);
          chk("overflow", overflow, e.ovf);
          chk("latency", rise_cyc - e.acc, N + 2);
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input int a, input int b);
    int g = 0;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      chk("issue_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    dividend = a[N-1:0];
    divisor  = b[N-1:0];
    if (check_spacing && last_acc >= 0) chk("accept_spacing", cyc - last_acc, N + 3);
    last_acc = cyc;
    sb.push_back(model(a, b, cyc));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((sb.size() != 0 || out_valid) && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() != 0 || out_valid) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int va[11] = '{100, -100, 100, -100, -128, -128, 127, 3, -128, 5, 36};
    int vb[11] = '{7, 7, -7, -7, 127, -110, -128, 4, -1, 0, 4};
    logic [N-1:0] q0;
    logic [N-1:0] r0;
    int g;
    int a;
    int b;
    logic seen_vld;

    // Reset state, with in_valid asserted to show it is ignored while held in reset.
    in_valid = 1'b1;
    dividend = 8'd50;
    divisor  = 8'd5;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_div_by_zero", div_by_zero, 0);
    chk("rst_overflow", overflow, 0);
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    // Directed quadrants, extremes, overflow, divide-by-zero and flag clearing.
    out_ready = 1'b1;
    foreach (va[i]) begin
      issue(va[i], vb[i]);
      wait_drain();
    end

    // Backpressure with stray in_valid pulses during CALC and DONE.
    out_ready = 1'b0;
    issue(-77, 9);
    g = 0;
    while (!out_valid && g < 40) begin
      in_valid = 1'($urandom_range(0, 1));
      dividend = N'($urandom);
      divisor  = N'($urandom);
      @(negedge clk);
      g++;
    end
    chk("bp_out_valid_seen", out_valid, 1);
    q0 = quotient;
    r0 = remainder;
    repeat (5) begin
      in_valid = 1'($urandom_range(0, 1));
      dividend = N'($urandom);
      @(negedge clk);
      chk("bp_quotient_stable", quotient, q0);
      chk("bp_remainder_stable", remainder, r0);
      chk("bp_out_valid_held", out_valid, 1);
      chk("bp_in_ready_low", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_in_ready", in_ready, 1);
    chk("bp_idle_out_valid", out_valid, 0);
    wait_drain();

    // Back-to-back random operands with out_ready tied high.
    check_spacing = 1'b1;
    last_acc      = -1;
    for (int i = 0; i < 16; i++) begin
      a = int'($urandom_range(0, 255)) - 128;
      b = int'($urandom_range(0, 255)) - 128;
      issue(a, b);
    end
    wait_drain();
    check_spacing = 1'b0;

    // Reset during CALC iteration 3 discards the pending result.
    issue(50, 3);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n    = 1'b1;
    seen_vld = 1'b0;
    repeat (N + 4) begin
      @(negedge clk);
      if (out_valid) seen_vld = 1'b1;
    end
    chk("abort_no_result", seen_vld, 0);
    chk("abort_idle", in_ready, 1);
    issue(72, -5);
    wait_drain();

    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
